uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial UART receiver, 8N1, LSB first. Downstream partner of the UART transmitter.
//   Takes the asynchronous serial line and samples each bit at mid-period.
//   Checks the start and stop bits, then presents the received byte with a one-cycle strobe.
//   Sits between the board RX pin and the byte-consuming logic.
// PARAMETERS
//   CLKS_PER_BIT  10417  clk cycles per bit (100 MHz / 9600 baud); legal range 4..65535
//   HALF_BIT      CLKS_PER_BIT/2  cycles from detected start edge to start-bit sample point
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   rx         in   1  serial input, asynchronous to clk, idles high
//   data       out  8  last correctly framed byte; held until the next good frame
//   rx_done    out  1  one-cycle pulse: data just updated with a good frame
//   frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (sampled on posedge clk while reset=1):
//     data=0, rx_done=0, frame_err=0, busy=0, state=IDLE.
//     Counters and shift register = 0; synchroniser flops = 1.
//     Reset during a frame abandons it; no strobe is issued.
//   Input sync: rx passes through 2 flops -> rx_s; all decisions use rx_s only (2-cycle delay).
//   Counter: 16 bit, cleared on every state change; bit_idx is 3 bit.
//   IDLE: rx_s==0 -> START.
//   START: at counter==HALF_BIT-1, sample rx_s.
//     If 0 -> DATA, bit_idx=0.
//     If 1 -> IDLE (glitch/false start); no strobe.
//   DATA: at counter==CLKS_PER_BIT-1, shift[bit_idx] <= rx_s.
//     bit_idx==7 -> STOP; otherwise bit_idx+1.
//   STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
//     If 1 -> data<=shift, rx_done=1 for exactly one cycle, go to IDLE.
//     If 0 -> frame_err=1 for one cycle, data unchanged, go to BREAK.
//   BREAK: wait for rx_s==1, then go to IDLE. A held-low line (break) yields exactly one
//     frame_err, not repeated frames.
//   rx_done and frame_err are never high together and are never high in consecutive cycles.
//   A start bit may begin on the cycle immediately after the STOP sample (back-to-back frames).
//     Because the STOP sample lands at mid-bit, at most a half-bit of dead time is lost.
//   Latency: rx_done rises HALF_BIT + 9*CLKS_PER_BIT + 3..4 cycles after the rx falling edge.
//   Baud tolerance: a frame must be received correctly with up to +/-2% rate mismatch.
//   busy=1 from the cycle after entering START until the cycle IDLE is re-entered.
// TESTING (bench uses CLKS_PER_BIT=16; drive rx with a bit-accurate task)
//   1. Reset, line idle high for 100 cycles -> no strobes, busy=0, data=0x00.
//   2. Send 0xA5 -> single rx_done pulse, data=0xA5, frame_err never high.
//      rx_done lands within the latency window above.
//   3. Send 0x00, 0xFF, 0x5A back-to-back (no idle gap) -> three rx_done pulses,
//      data sequence 0x00, 0xFF, 0x5A.
//   4. Low glitch of 5 cycles on idle line -> busy rises then falls, no rx_done, no frame_err.
//   5. Send 0x3C with stop bit forced low, hold low 40 cycles, release, then send 0x81.
//      -> exactly one frame_err, data stays at its prior value, then rx_done with data=0x81.
//   6. Assert reset at bit 4 of 0xC3, release, send 0x7E -> no strobe for 0xC3;
//      rx_done with data=0x7E. Also loop back the transmitter (same CLKS_PER_BIT) and
//      check 0x00..0xFF received in order.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop input synchroniser, mid-bit sampling,
// start/stop validation, one-cycle rx_done / frame_err strobes.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_s;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        done_n, ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
    end
  end

  // Every branch that changes state also clears the counter.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model (queue of expected strobes from a behavioural
// transmitter) checked every cycle, plus directed literal expectations.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned LAT  = HALF + 9 * CPB;
  localparam int unsigned TCLK = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       rx_done, frame_err, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_done = 0;
  int unsigned n_ferr = 0;

  typedef struct {
    bit       is_err;
    bit [7:0] b;
    longint   t_fall;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] model_data = 8'h00;
  bit         strobe_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data),
    .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural transmitter; queues the outcome the receiver must report.
  task automatic send(input logic [7:0] b, input int unsigned bit_ns, input bit stop_ok,
                      input int unsigned extra_low_ns);
    frame_t f;
    f.is_err = !stop_ok;
    f.b      = b;
    f.t_fall = $time;
    exp_q.push_back(f);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_ok;
    #(bit_ns);
    if (!stop_ok) begin
      #(extra_low_ns);
      rx = 1'b1;
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    longint lat;
    frame_t e;
    if (reset) begin
      model_data  = 8'h00;
      strobe_prev = 1'b0;
    end else begin
      if (rx_done || frame_err) begin
        check("strobe_exclusive", {31'd0, rx_done & frame_err}, 0);
        check("strobe_gap", {31'd0, strobe_prev}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got done=%0b err=%0b expected none at %0t",
                   rx_done, frame_err, $time);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
          if (!e.is_err) model_data = e.b;
          check("data_on_strobe", {24'd0, data}, {24'd0, model_data});
          lat = ($time - 5 - e.t_fall + TCLK - 1) / TCLK;
          checks++;
          if (lat < LAT + 3 || lat > LAT + 4) begin
            errors++;
            $display("FAIL latency got %0d cycles expected %0d..%0d", lat, LAT + 3, LAT + 4);
          end
        end
        if (rx_done) n_done++;
        if (frame_err) n_ferr++;
      end else begin
        check("data_held", {24'd0, data}, {24'd0, model_data});
      end
      strobe_prev = rx_done | frame_err;
      if (exp_q.size() != 0 && ($time - exp_q[0].t_fall) > longint'((LAT + 12) * TCLK)) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe got none expected byte %0h err=%0b", exp_q[0].b, exp_q[0].is_err);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit busy_seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle line
    repeat (100) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_data", {24'd0, data}, 32'h00);
    check("idle_strobes", n_done + n_ferr, 0);

    // 2: single frame
    align();
    fork
      send(8'hA5, CPB * TCLK, 1'b1, 0);
      begin
        repeat (50) @(posedge clk);
        #1 check("busy_in_frame", {31'd0, busy}, 1);
      end
    join
    wait_drain("drain_a5", 40);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_done_cnt", n_done, 1);
    check("a5_ferr_cnt", n_ferr, 0);

    // 3: back-to-back frames
    align();
    send(8'h00, CPB * TCLK, 1'b1, 0);
    send(8'hFF, CPB * TCLK, 1'b1, 0);
    send(8'h5A, CPB * TCLK, 1'b1, 0);
    wait_drain("drain_b2b", 40);
    check("b2b_data", {24'd0, data}, 32'h5A);
    check("b2b_done_cnt", n_done, 4);

    // 4: 5-cycle glitch
    repeat (20) @(posedge clk);
    align();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch_busy_rise", {31'd0, busy_seen}, 1);
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_fall", {31'd0, busy}, 0);
    check("glitch_done_cnt", n_done, 4);
    check("glitch_ferr_cnt", n_ferr, 0);

    // 5: framing error with held break, then recovery
    align();
    send(8'h3C, CPB * TCLK, 1'b0, 40 * TCLK);
    wait_drain("drain_break", 40);
    check("break_ferr_cnt", n_ferr, 1);
    check("break_data_kept", {24'd0, data}, 32'h5A);
    repeat (20) @(posedge clk);
    check("break_ferr_once", n_ferr, 1);
    align();
    send(8'h81, CPB * TCLK, 1'b1, 0);
    wait_drain("drain_81", 40);
    check("after_break_data", {24'd0, data}, 32'h81);
    check("after_break_done_cnt", n_done, 5);

    // 6: reset in the middle of 0xC3, frame abandoned
    align();
    rx = 1'b0;
    #(CPB * TCLK);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'hC3 >> i) & 8'h01) != 0;
      #(CPB * TCLK);
    end
    align();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (300) @(posedge clk);
    check("abandon_done_cnt", n_done, 5);
    check("abandon_data_reset", {24'd0, data}, 32'h00);
    align();
    send(8'h7E, CPB * TCLK, 1'b1, 0);
    wait_drain("drain_7e", 40);
    check("post_reset_data", {24'd0, data}, 32'h7E);
    check("post_reset_done_cnt", n_done, 6);

    // baud mismatch of about +/-1.9%
    align();
    send(8'h96, 163, 1'b1, 0);
    wait_drain("drain_slow", 40);
    check("slow_data", {24'd0, data}, 32'h96);
    align();
    send(8'h69, 157, 1'b1, 0);
    wait_drain("drain_fast", 40);
    check("fast_data", {24'd0, data}, 32'h69);
    check("tol_done_cnt", n_done, 8);

    // loopback sweep 0x00..0xFF back-to-back
    align();
    for (int i = 0; i < 256; i++) send(8'(i), CPB * TCLK, 1'b1, 0);
    wait_drain("drain_sweep", 40);
    check("sweep_done_cnt", n_done, 264);
    check("sweep_ferr_cnt", n_ferr, 1);
    check("sweep_last_data", {24'd0, data}, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
